// File: rtl/hvtx_pixfeed.sv
// ============================================================================
// Module   : hvtx_pixfeed
// Purpose  : Buffers an upstream pixel stream in a small FIFO and replays it
//            in lock-step with the local raster timing (hs/vs/de) towards the
//            TMDS modulator. Tracks the raster position so that a start-of-
//            frame marker arriving anywhere other than pixel (0,0), or a
//            missing marker at (0,0), or a FIFO underflow, forces a one-cycle
//            resynchronisation back to waiting for the next start of frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk        in   pixel clock, rising-edge
//   i_rst_n      in   asynchronous active-low reset
//   i_hs/vs/de   in   raster timing from the sync generator
//   s_valid      in   upstream beat valid
//   s_ready      out  upstream beat accepted when s_valid && s_ready
//   s_data       in   pixel, channel 0 = B, 1 = G, 2 = R
//   s_sof        in   first pixel of a frame
//   o_hs/vs/de   out  timing inputs delayed one cycle
//   o_video      out  pixel aligned with o_de (zero whenever o_de is low)
//   o_locked     out  high while armed or streaming
//   o_underflow  out  one-cycle pulse on every resync event
// ============================================================================
`default_nettype none

module hvtx_pixfeed #(
  parameter int               WIDTH         = 12,
  parameter logic [WIDTH-1:0] ACTIVE_WIDTH  = WIDTH'(1280),
  parameter logic [WIDTH-1:0] ACTIVE_HEIGHT = WIDTH'(720),
  parameter int               DEPTH         = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_hs,
  input  logic            i_vs,
  input  logic            i_de,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [2:0][7:0] s_data,
  input  logic            s_sof,
  output logic            o_hs,
  output logic            o_vs,
  output logic            o_de,
  output logic [2:0][7:0] o_video,
  output logic            o_locked,
  output logic            o_underflow
);

  localparam int               AW     = $clog2(DEPTH);
  localparam int               EW     = 25;
  localparam logic [WIDTH-1:0] X_LAST = ACTIVE_WIDTH - WIDTH'(1);
  localparam logic [WIDTH-1:0] Y_LAST = ACTIVE_HEIGHT - WIDTH'(1);

  typedef enum logic [2:0] {
    WAIT_SOF = 3'd0,
    FILL     = 3'd1,
    ARMED    = 3'd2,
    STREAM   = 3'd3,
    RESYNC   = 3'd4
  } state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [WIDTH-1:0] x_cnt;
  logic [WIDTH-1:0] y_cnt;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop_req;
  logic            pop;
  logic            vs_rise;
  logic            head_sof;
  logic [2:0][7:0] head_data;
  logic            at_origin;
  logic            misalign;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // While hunting for a frame start every beat is taken so junk drains away;
  // only the marked beat is actually written.
  assign s_ready = (state == WAIT_SOF) || ((state != RESYNC) && !full);
  assign push    = s_valid && s_ready && ((state != WAIT_SOF) || s_sof);

  // ARMED pops on its first active cycle together with the move to STREAM.
  assign pop_req = i_de && ((state == ARMED) || (state == STREAM));
  assign pop     = pop_req && !empty;

  assign {head_sof, head_data} = mem[rd_ptr[AW-1:0]];

  // The registered copy of i_vs doubles as the edge-detect history.
  assign vs_rise   = i_vs && !o_vs;
  assign at_origin = (x_cnt == '0) && (y_cnt == '0);
  assign misalign  = (head_sof != at_origin);

  // Storage is not reset: occupancy is fully described by the pointers.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {s_sof, s_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= WAIT_SOF;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      o_hs        <= 1'b0;
      o_vs        <= 1'b0;
      o_de        <= 1'b0;
      o_video     <= '0;
      o_locked    <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_hs        <= i_hs;
      o_vs        <= i_vs;
      o_de        <= i_de;
      o_video     <= '0;
      o_underflow <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        o_video <= head_data;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end

      case (state)
        WAIT_SOF: begin
          if (push) begin
            state <= FILL;
          end
        end

        FILL: begin
          if (vs_rise) begin
            state    <= ARMED;
            o_locked <= 1'b1;
          end
        end

        ARMED, STREAM: begin
          if (pop_req) begin
            // Empty is tested first: on an empty FIFO the head entry is stale.
            if (empty || misalign) begin
              state       <= RESYNC;
              o_locked    <= 1'b0;
              o_underflow <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end

        RESYNC: begin
          state  <= WAIT_SOF;
          wr_ptr <= '0;
          rd_ptr <= '0;
          x_cnt  <= '0;
          y_cnt  <= '0;
        end

        default: begin
          state    <= WAIT_SOF;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hvtx_pixfeed.sv
// ============================================================================
// Module   : tb_hvtx_pixfeed
// Purpose  : Directed self-checking bench for hvtx_pixfeed with a 4x2 raster
//            and a 4-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hvtx_pixfeed;

  logic            clk;
  logic            rst_n;
  logic            i_hs;
  logic            i_vs;
  logic            i_de;
  logic            s_valid;
  logic            s_ready;
  logic [2:0][7:0] s_data;
  logic            s_sof;
  logic            o_hs;
  logic            o_vs;
  logic            o_de;
  logic [2:0][7:0] o_video;
  logic            o_locked;
  logic            o_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream source: beats are offered in order, advancing on each handshake.
  logic [23:0] src_d [16];
  logic        src_s [16];
  int          src_n   = 0;
  int          src_idx = 0;

  hvtx_pixfeed #(
    .WIDTH        (12),
    .ACTIVE_WIDTH (12'd4),
    .ACTIVE_HEIGHT(12'd2),
    .DEPTH        (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_hs       (i_hs),
    .i_vs       (i_vs),
    .i_de       (i_de),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_de       (o_de),
    .o_video    (o_video),
    .o_locked   (o_locked),
    .o_underflow(o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] beat(input int k);
    return 24'h102030 + 24'(k) * 24'h010101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    if (src_idx < src_n) begin
      s_valid = 1'b1;
      s_data  = src_d[src_idx];
      s_sof   = src_s[src_idx];
    end else begin
      s_valid = 1'b0;
      s_data  = '0;
      s_sof   = 1'b0;
    end
  endtask

  // One clock: handshake is judged just before the edge, outputs are
  // observed 1 time unit after it.
  task automatic cycle();
    logic fire;
    fire = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (fire) src_idx++;
    drive_src();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0;
    src_n = 0; src_idx = 0;
    drive_src();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_after_release", 32'(s_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0;
    drive_src();
    @(posedge clk); #1;
    chk("rst_video",     32'(o_video),     32'd0);
    chk("rst_de",        32'(o_de),        32'd0);
    chk("rst_locked",    32'(o_locked),    32'd0);
    chk("rst_underflow", 32'(o_underflow), 32'd0);
    chk("rst_ready",     32'(s_ready),     32'd1);
    do_reset();

    // ---------------- normal frame, then wrap into the next frame ---------
    src_n = 10;
    for (int k = 0; k < 10; k++) begin
      src_d[k] = beat(k);
      src_s[k] = (k == 0) || (k == 8);
    end
    src_idx = 0;
    drive_src();
    repeat (6) cycle();
    chk("t1_accepted", 32'(src_idx),  32'd4);
    chk("t1_full",     32'(s_ready),  32'd0);
    chk("t1_unlocked", 32'(o_locked), 32'd0);
    i_vs = 1'b1; cycle(); i_vs = 1'b0;
    chk("t1_vs",     32'(o_vs),     32'd1);
    chk("t1_locked", 32'(o_locked), 32'd1);
    i_de = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t1_de",    32'(o_de),        32'd1);
      chk("t1_video", 32'(o_video),     32'(beat(k)));
      chk("t1_uf",    32'(o_underflow), 32'd0);
    end
    i_de = 1'b0;
    cycle();
    chk("t1_blank_de",    32'(o_de),    32'd0);
    chk("t1_blank_video", 32'(o_video), 32'd0);
    cycle();
    i_de = 1'b1;
    for (int k = 4; k < 9; k++) begin
      cycle();
      chk("t1_video2", 32'(o_video),     32'(beat(k)));
      chk("t1_uf2",    32'(o_underflow), 32'd0);
    end
    i_de = 1'b0;
    cycle();
    chk("t1_still_locked", 32'(o_locked),    32'd1);
    chk("t1_uf_end",       32'(o_underflow), 32'd0);

    // ---------------- underflow after 5 beats ----------------------------
    do_reset();
    src_n = 5;
    for (int k = 0; k < 5; k++) begin
      src_d[k] = beat(k);
      src_s[k] = (k == 0);
    end
    src_idx = 0;
    drive_src();
    repeat (6) cycle();
    i_vs = 1'b1; cycle(); i_vs = 1'b0;
    i_de = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t2_video", 32'(o_video),     32'(beat(k)));
      chk("t2_uf",    32'(o_underflow), 32'd0);
    end
    cycle();
    chk("t2_uf_de",     32'(o_de),        32'd1);
    chk("t2_uf_video",  32'(o_video),     32'd0);
    chk("t2_uf_pulse",  32'(o_underflow), 32'd1);
    chk("t2_uf_unlock", 32'(o_locked),    32'd0);
    cycle();
    chk("t2_uf_once", 32'(o_underflow), 32'd0);
    cycle();
    chk("t2_uf_once2", 32'(o_underflow), 32'd0);
    chk("t2_wait_sof", 32'(s_ready),     32'd1);
    i_de = 1'b0;

    // ---------------- misaligned sof on third beat -----------------------
    do_reset();
    src_n = 6;
    for (int k = 0; k < 6; k++) begin
      src_d[k] = beat(k);
      src_s[k] = (k == 0) || (k == 2);
    end
    src_idx = 0;
    drive_src();
    repeat (6) cycle();
    i_vs = 1'b1; cycle(); i_vs = 1'b0;
    i_de = 1'b1;
    cycle();
    chk("t3_video0", 32'(o_video),     32'(beat(0)));
    chk("t3_uf0",    32'(o_underflow), 32'd0);
    cycle();
    chk("t3_video1", 32'(o_video),     32'(beat(1)));
    chk("t3_uf1",    32'(o_underflow), 32'd0);
    cycle();
    chk("t3_video2", 32'(o_video),     32'(beat(2)));
    chk("t3_uf2",    32'(o_underflow), 32'd1);
    i_de = 1'b0;
    cycle();
    chk("t3_uf3", 32'(o_underflow), 32'd0);
    // Five unmarked beats: all taken (dropped), so the FIFO never fills.
    src_n = 5;
    for (int k = 0; k < 5; k++) begin
      src_d[k] = beat(k + 20);
      src_s[k] = 1'b0;
    end
    src_idx = 0;
    drive_src();
    repeat (5) cycle();
    chk("t3_junk_taken", 32'(src_idx), 32'd5);
    chk("t3_junk_ready", 32'(s_ready), 32'd1);
    i_vs = 1'b1; cycle(); i_vs = 1'b0;
    chk("t3_no_lock", 32'(o_locked), 32'd0);

    // ---------------- full FIFO, de outside STREAM -----------------------
    do_reset();
    src_n = 6;
    for (int k = 0; k < 6; k++) begin
      src_d[k] = beat(k + 40);
      src_s[k] = (k == 0);
    end
    src_idx = 0;
    drive_src();
    repeat (4) cycle();
    chk("t4_acc4",  32'(src_idx), 32'd4);
    chk("t4_ready", 32'(s_ready), 32'd0);
    repeat (2) cycle();
    chk("t4_acc4b", 32'(src_idx), 32'd4);
    i_de = 1'b1; cycle(); i_de = 1'b0;
    chk("t4_fill_de",    32'(o_de),     32'd1);
    chk("t4_fill_video", 32'(o_video),  32'd0);
    chk("t4_fill_lock",  32'(o_locked), 32'd0);
    i_vs = 1'b1; cycle(); i_vs = 1'b0;
    chk("t4_armed_full", 32'(s_ready), 32'd0);
    i_de = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t4_order", 32'(o_video), 32'(beat(k + 40)));
      if (k == 0) chk("t4_ready_after_pop", 32'(s_ready), 32'd1);
    end
    i_de = 1'b0;
    chk("t4_all_taken", 32'(src_idx), 32'd6);

    // ---------------- junk before sof ------------------------------------
    do_reset();
    src_n = 5;
    src_d[0] = 24'h111111; src_s[0] = 1'b0;
    src_d[1] = 24'h222222; src_s[1] = 1'b0;
    src_d[2] = 24'h333333; src_s[2] = 1'b0;
    src_d[3] = 24'hAABBCC; src_s[3] = 1'b1;
    src_d[4] = 24'h000001; src_s[4] = 1'b0;
    src_idx = 0;
    drive_src();
    repeat (6) cycle();
    i_vs = 1'b1; cycle(); i_vs = 1'b0;
    i_hs = 1'b1; i_de = 1'b1;
    cycle();
    chk("t5_first", 32'(o_video), 32'hAABBCC);
    chk("t5_hs",    32'(o_hs),    32'd1);
    cycle();
    chk("t5_second", 32'(o_video),  32'h000001);
    chk("t5_locked", 32'(o_locked), 32'd1);

    // ---------------- asynchronous reset mid-STREAM ----------------------
    i_de = 1'b0; i_hs = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_video",  32'(o_video),     32'd0);
    chk("t6_de",     32'(o_de),        32'd0);
    chk("t6_hs",     32'(o_hs),        32'd0);
    chk("t6_locked", 32'(o_locked),    32'd0);
    chk("t6_uf",     32'(o_underflow), 32'd0);
    @(posedge clk); #1;
    chk("t6_uf_edge", 32'(o_underflow), 32'd0);
    rst_n = 1'b1;
    chk("t6_ready", 32'(s_ready), 32'd1);
    i_vs = 1'b1; cycle(); i_vs = 1'b0;
    i_de = 1'b1; cycle(); i_de = 1'b0;
    chk("t6_no_lock",   32'(o_locked), 32'd0);
    chk("t6_discarded", 32'(o_video),  32'd0);
    chk("t6_de_out",    32'(o_de),     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
